// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches decoded operands and controls, forwards EX/MEM and MEM/WB results,
// selects immediate vs rs2, and inserts a one-cycle bubble on load-use. Define IDEX_PERF_CNT_EN for bubble_count.
module id_ex_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             id_valid,
    input  logic [WIDTH-1:0] id_pc,
    input  logic [WIDTH-1:0] id_rs1_data,
    input  logic [WIDTH-1:0] id_rs2_data,
    input  logic [WIDTH-1:0] id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic [3:0]       id_func,
    input  logic [2:0]       id_alu_op,
    input  logic             id_alu_src,
    input  logic [3:0]       id_ctrl,
    input  logic             exm_reg_write,
    input  logic [4:0]       exm_rd,
    input  logic [WIDTH-1:0] exm_result,
    input  logic             mwb_reg_write,
    input  logic [4:0]       mwb_rd,
    input  logic [WIDTH-1:0] mwb_result,
    input  logic             flush,
    input  logic             mem_stall,
    output logic             id_stall,
    output logic             ex_valid,
    output logic [WIDTH-1:0] ex_pc,
    output logic [WIDTH-1:0] ex_dataA,
    output logic [WIDTH-1:0] ex_dataB,
    output logic [WIDTH-1:0] ex_store_data,
    output logic [3:0]       ex_func,
    output logic [2:0]       ex_alu_op,
    output logic [4:0]       ex_rd,
    output logic [3:0]       ex_ctrl
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [31:0]      bubble_count
`endif
);

    // ctrl layout is {branch, reg_write, mem_write, mem_read}
    localparam int CTRL_MEM_READ = 0;

    logic             valid_q,    valid_d;
    logic [WIDTH-1:0] pc_q,       pc_d;
    logic [WIDTH-1:0] rs1_data_q, rs1_data_d;
    logic [WIDTH-1:0] rs2_data_q, rs2_data_d;
    logic [WIDTH-1:0] imm_q,      imm_d;
    logic [4:0]       rs1_q,      rs1_d;
    logic [4:0]       rs2_q,      rs2_d;
    logic [4:0]       rd_q,       rd_d;
    logic [3:0]       func_q,     func_d;
    logic [2:0]       alu_op_q,   alu_op_d;
    logic             alu_src_q,  alu_src_d;
    logic [3:0]       ctrl_q,     ctrl_d;

    logic             hazard;
    logic             bubble_ins;
    logic [WIDTH-1:0] fwd_rs1;
    logic [WIDTH-1:0] fwd_rs2;

    function automatic logic [WIDTH-1:0] forward(
        input logic [4:0]       src,
        input logic [WIDTH-1:0] reg_val,
        input logic             exm_we,
        input logic [4:0]       exm_dst,
        input logic [WIDTH-1:0] exm_val,
        input logic             mwb_we,
        input logic [4:0]       mwb_dst,
        input logic [WIDTH-1:0] mwb_val
    );
        logic [WIDTH-1:0] res;
        res = reg_val;
        if (exm_we && exm_dst != 5'd0 && exm_dst == src)
            res = exm_val;
        else if (mwb_we && mwb_dst != 5'd0 && mwb_dst == src)
            res = mwb_val;
        return res;
    endfunction

    always_comb begin
        hazard = valid_q & ctrl_q[CTRL_MEM_READ] & (rd_q != 5'd0) & id_valid
               & ((id_rs1 == rd_q) | (id_rs2 == rd_q));
        id_stall   = mem_stall | hazard;
        // Only a genuine load-use bubble counts; stall and flush take priority.
        bubble_ins = hazard & ~mem_stall & ~flush;
    end

    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        func_d     = func_q;
        alu_op_d   = alu_op_q;
        alu_src_d  = alu_src_q;
        ctrl_d     = ctrl_q;
        if (mem_stall) begin
            valid_d = valid_q;
        end else if (flush || hazard) begin
            valid_d = 1'b0;
        end else begin
            valid_d    = id_valid;
            pc_d       = id_pc;
            rs1_data_d = id_rs1_data;
            rs2_data_d = id_rs2_data;
            imm_d      = id_imm;
            rs1_d      = id_rs1;
            rs2_d      = id_rs2;
            rd_d       = id_rd;
            func_d     = id_func;
            alu_op_d   = id_alu_op;
            alu_src_d  = id_alu_src;
            ctrl_d     = id_ctrl;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            func_q     <= '0;
            alu_op_q   <= '0;
            alu_src_q  <= 1'b0;
            ctrl_q     <= '0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            func_q     <= func_d;
            alu_op_q   <= alu_op_d;
            alu_src_q  <= alu_src_d;
            ctrl_q     <= ctrl_d;
        end
    end

    always_comb begin
        fwd_rs1 = forward(rs1_q, rs1_data_q, exm_reg_write, exm_rd, exm_result,
                          mwb_reg_write, mwb_rd, mwb_result);
        fwd_rs2 = forward(rs2_q, rs2_data_q, exm_reg_write, exm_rd, exm_result,
                          mwb_reg_write, mwb_rd, mwb_result);
        ex_valid      = valid_q;
        ex_pc         = pc_q;
        ex_dataA      = fwd_rs1;
        ex_dataB      = alu_src_q ? imm_q : fwd_rs2;
        ex_store_data = fwd_rs2;
        ex_func       = func_q;
        ex_alu_op     = alu_op_q;
        ex_rd         = rd_q;
        ex_ctrl       = ctrl_q & {4{valid_q}};
    end

`ifdef IDEX_PERF_CNT_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (bubble_ins && bubble_cnt_q != 32'hFFFF_FFFF)
            bubble_cnt_d = bubble_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            bubble_cnt_q <= '0;
        else
            bubble_cnt_q <= bubble_cnt_d;
    end

    assign bubble_count = bubble_cnt_q;
`else
    logic unused_bubble;
    assign unused_bubble = bubble_ins;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: reset, operand latch, forwarding priority, load-use, flush/stall.
module tb_id_ex_stage;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         id_valid;
    logic [W-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]   id_rs1, id_rs2, id_rd;
    logic [3:0]   id_func;
    logic [2:0]   id_alu_op;
    logic         id_alu_src;
    logic [3:0]   id_ctrl;
    logic         exm_reg_write, mwb_reg_write;
    logic [4:0]   exm_rd, mwb_rd;
    logic [W-1:0] exm_result, mwb_result;
    logic         flush, mem_stall;
    logic         id_stall, ex_valid;
    logic [W-1:0] ex_pc, ex_dataA, ex_dataB, ex_store_data;
    logic [3:0]   ex_func;
    logic [2:0]   ex_alu_op;
    logic [4:0]   ex_rd;
    logic [3:0]   ex_ctrl;
`ifdef IDEX_PERF_CNT_EN
    logic [31:0]  bubble_count;
    logic [31:0]  cnt_before;
`endif

    int vecs  = 0;
    int fails = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_func(id_func),
        .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_ctrl(id_ctrl),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
        .flush(flush), .mem_stall(mem_stall), .id_stall(id_stall), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_dataA(ex_dataA), .ex_dataB(ex_dataB),
        .ex_store_data(ex_store_data), .ex_func(ex_func), .ex_alu_op(ex_alu_op),
        .ex_rd(ex_rd), .ex_ctrl(ex_ctrl)
`ifdef IDEX_PERF_CNT_EN
        , .bubble_count(bubble_count)
`endif
    );

    task automatic idle();
        id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_func = 0; id_alu_op = 0; id_alu_src = 0; id_ctrl = 0;
        exm_reg_write = 0; exm_rd = 0; exm_result = 0;
        mwb_reg_write = 0; mwb_rd = 0; mwb_result = 0;
        flush = 0; mem_stall = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle();
        #1;
        vecs++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %0h want 0", ex_valid); end
        vecs++; if (ex_ctrl !== 4'h0) begin fails++; $display("FAIL rst_ctrl: got %0h want 0", ex_ctrl); end
        vecs++; if (ex_dataA !== 32'h0) begin fails++; $display("FAIL rst_dataA: got %0h want 0", ex_dataA); end
        vecs++; if (id_stall !== 1'b0) begin fails++; $display("FAIL rst_id_stall: got %0h want 0", id_stall); end
        @(negedge clk);
        reset_n = 1'b1;
        step();
        id_valid = 1; id_pc = 32'h40; id_rs1 = 5'd1; id_rs1_data = 32'h55; id_ctrl = 4'b0100;
        step();
        vecs++; if (ex_dataA !== 32'h55) begin fails++; $display("FAIL pre_rst_dataA: got %0h want 55", ex_dataA); end
        // async reset while a stall and flush are pending
        mem_stall = 1; flush = 1;
        #2;
        reset_n = 1'b0;
        #1;
        vecs++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL async_rst_valid: got %0h want 0", ex_valid); end
        vecs++; if (ex_ctrl !== 4'h0) begin fails++; $display("FAIL async_rst_ctrl: got %0h want 0", ex_ctrl); end
        vecs++; if (ex_dataA !== 32'h0) begin fails++; $display("FAIL async_rst_dataA: got %0h want 0", ex_dataA); end
        vecs++; if (ex_pc !== 32'h0) begin fails++; $display("FAIL async_rst_pc: got %0h want 0", ex_pc); end
        @(negedge clk);
        reset_n = 1'b1; mem_stall = 0; flush = 0; id_pc = 32'h80;
        step();
        vecs++; if (ex_valid !== 1'b1) begin fails++; $display("FAIL post_rst_valid: got %0h want 1", ex_valid); end
        vecs++; if (ex_pc !== 32'h80) begin fails++; $display("FAIL post_rst_pc: got %0h want 80", ex_pc); end
    endtask

    task automatic test_normal();
        idle();
        id_valid = 1; id_pc = 32'h100; id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd6;
        id_rs1_data = 32'd5; id_rs2_data = 32'd9; id_imm = 32'd7; id_alu_src = 1;
        id_func = 4'h0; id_alu_op = 3'b010; id_ctrl = 4'b0100;
        step();
        vecs++; if (ex_valid !== 1'b1) begin fails++; $display("FAIL norm_valid: got %0h want 1", ex_valid); end
        vecs++; if (ex_dataA !== 32'd5) begin fails++; $display("FAIL norm_dataA: got %0h want 5", ex_dataA); end
        vecs++; if (ex_dataB !== 32'd7) begin fails++; $display("FAIL norm_dataB_imm: got %0h want 7", ex_dataB); end
        vecs++; if (ex_store_data !== 32'd9) begin fails++; $display("FAIL norm_store: got %0h want 9", ex_store_data); end
        vecs++; if (ex_pc !== 32'h100) begin fails++; $display("FAIL norm_pc: got %0h want 100", ex_pc); end
        vecs++; if (ex_rd !== 5'd6) begin fails++; $display("FAIL norm_rd: got %0h want 6", ex_rd); end
        vecs++; if (ex_alu_op !== 3'b010) begin fails++; $display("FAIL norm_alu_op: got %0h want 2", ex_alu_op); end
        vecs++; if (ex_ctrl !== 4'b0100) begin fails++; $display("FAIL norm_ctrl: got %0h want 4", ex_ctrl); end
        id_pc = 32'h104; id_alu_src = 0; id_rs2_data = 32'h33; id_func = 4'hD; id_alu_op = 3'b011;
        step();
        vecs++; if (ex_dataB !== 32'h33) begin fails++; $display("FAIL norm_dataB_rs2: got %0h want 33", ex_dataB); end
        vecs++; if (ex_func !== 4'hD) begin fails++; $display("FAIL norm_func: got %0h want d", ex_func); end
        id_valid = 0;
        step();
        vecs++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL norm_invalid: got %0h want 0", ex_valid); end
        vecs++; if (ex_ctrl !== 4'h0) begin fails++; $display("FAIL norm_invalid_ctrl: got %0h want 0", ex_ctrl); end
    endtask

    task automatic test_forward();
        idle();
        id_valid = 1; id_rs1 = 5'd3; id_rs2 = 5'd3; id_rs1_data = 32'h11; id_rs2_data = 32'h22; id_rd = 5'd7;
        step();
        vecs++; if (ex_dataA !== 32'h11) begin fails++; $display("FAIL fwd_none: got %0h want 11", ex_dataA); end
        exm_reg_write = 1; exm_rd = 5'd3; exm_result = 32'hAA;
        mwb_reg_write = 1; mwb_rd = 5'd3; mwb_result = 32'hBB;
        #1;
        vecs++; if (ex_dataA !== 32'hAA) begin fails++; $display("FAIL fwd_exm_pri: got %0h want aa", ex_dataA); end
        vecs++; if (ex_dataB !== 32'hAA) begin fails++; $display("FAIL fwd_exm_B: got %0h want aa", ex_dataB); end
        exm_reg_write = 0;
        #1;
        vecs++; if (ex_dataA !== 32'hBB) begin fails++; $display("FAIL fwd_mwb: got %0h want bb", ex_dataA); end
        exm_reg_write = 1; exm_rd = 5'd5;
        #1;
        vecs++; if (ex_store_data !== 32'hBB) begin fails++; $display("FAIL fwd_exm_miss: got %0h want bb", ex_store_data); end
        mwb_reg_write = 0;
        #1;
        vecs++; if (ex_dataA !== 32'h11) begin fails++; $display("FAIL fwd_off: got %0h want 11", ex_dataA); end
        exm_reg_write = 0; id_rs1 = 5'd0; id_rs1_data = 32'h77;
        step();
        exm_reg_write = 1; exm_rd = 5'd0; exm_result = 32'hAA;
        mwb_reg_write = 1; mwb_rd = 5'd0; mwb_result = 32'hBB;
        #1;
        vecs++; if (ex_dataA !== 32'h77) begin fails++; $display("FAIL fwd_x0: got %0h want 77", ex_dataA); end
    endtask

    task automatic test_load_use();
        idle();
        id_valid = 1; id_rd = 5'd4; id_rs1 = 5'd2; id_ctrl = 4'b0101; id_pc = 32'h300;
        step();
        id_pc = 32'h304; id_rs1 = 5'd4; id_rs2 = 5'd1; id_rd = 5'd5; id_ctrl = 4'b0100;
        id_rs1_data = 32'h0; id_rs2_data = 32'h10; id_alu_src = 0;
        #1;
        vecs++; if (id_stall !== 1'b1) begin fails++; $display("FAIL lu_stall: got %0h want 1", id_stall); end
        step();
        exm_reg_write = 1; exm_rd = 5'd4; exm_result = 32'hDEAD;
        #1;
        vecs++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL lu_bubble_valid: got %0h want 0", ex_valid); end
        vecs++; if (ex_ctrl !== 4'h0) begin fails++; $display("FAIL lu_bubble_ctrl: got %0h want 0", ex_ctrl); end
        vecs++; if (id_stall !== 1'b0) begin fails++; $display("FAIL lu_stall_clear: got %0h want 0", id_stall); end
`ifdef IDEX_PERF_CNT_EN
        vecs++; if (bubble_count !== 32'd1) begin fails++; $display("FAIL lu_count: got %0d want 1", bubble_count); end
`endif
        step();
        exm_reg_write = 0; exm_rd = 5'd0;
        mwb_reg_write = 1; mwb_rd = 5'd4; mwb_result = 32'h44;
        #1;
        vecs++; if (ex_valid !== 1'b1) begin fails++; $display("FAIL lu_add_valid: got %0h want 1", ex_valid); end
        vecs++; if (ex_pc !== 32'h304) begin fails++; $display("FAIL lu_add_pc: got %0h want 304", ex_pc); end
        vecs++; if (ex_dataA !== 32'h44) begin fails++; $display("FAIL lu_add_fwd: got %0h want 44", ex_dataA); end
        vecs++; if (ex_store_data !== 32'h10) begin fails++; $display("FAIL lu_add_rs2: got %0h want 10", ex_store_data); end
        idle();
        id_valid = 1; id_rd = 5'd0; id_ctrl = 4'b0001;
        step();
        id_rs1 = 5'd0; id_ctrl = 4'b0100; id_rd = 5'd8;
        #1;
        vecs++; if (id_stall !== 1'b0) begin fails++; $display("FAIL lu_x0_nostall: got %0h want 0", id_stall); end
    endtask

    task automatic test_flush_stall();
        idle();
        id_valid = 1; id_pc = 32'h200; id_rd = 5'd9; id_ctrl = 4'b0100;
        step();
        id_pc = 32'h204; id_rd = 5'd10; flush = 1; mem_stall = 1;
        #1;
        vecs++; if (id_stall !== 1'b1) begin fails++; $display("FAIL fs_stall_out: got %0h want 1", id_stall); end
        step();
        vecs++; if (ex_valid !== 1'b1) begin fails++; $display("FAIL fs_hold_valid: got %0h want 1", ex_valid); end
        vecs++; if (ex_pc !== 32'h200) begin fails++; $display("FAIL fs_hold_pc: got %0h want 200", ex_pc); end
        mem_stall = 0;
        #1;
        vecs++; if (id_stall !== 1'b0) begin fails++; $display("FAIL fs_flush_nostall: got %0h want 0", id_stall); end
        step();
        vecs++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL fs_flush_valid: got %0h want 0", ex_valid); end
        vecs++; if (ex_ctrl !== 4'h0) begin fails++; $display("FAIL fs_flush_ctrl: got %0h want 0", ex_ctrl); end
    endtask

    task automatic test_flush_load_use();
        idle();
        id_valid = 1; id_rd = 5'd4; id_ctrl = 4'b0101;
        step();
`ifdef IDEX_PERF_CNT_EN
        cnt_before = bubble_count;
`endif
        id_rs2 = 5'd4; id_rs1 = 5'd1; id_rd = 5'd5; id_ctrl = 4'b0100; flush = 1;
        #1;
        vecs++; if (id_stall !== 1'b1) begin fails++; $display("FAIL fl_lu_stall: got %0h want 1", id_stall); end
        step();
        vecs++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL fl_lu_valid: got %0h want 0", ex_valid); end
`ifdef IDEX_PERF_CNT_EN
        vecs++; if (bubble_count !== cnt_before) begin fails++; $display("FAIL fl_lu_count: got %0d want %0d", bubble_count, cnt_before); end
`endif
        flush = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_normal();
        test_forward();
        test_load_use();
        test_flush_stall();
        test_flush_load_use();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule
